// File: rtl/dma_channel_arbiter.sv
// Four-channel DMA engine arbiter: IDLE -> GRANT -> XFER -> RELEASE, with burst limit and sticky error.
// Define DMA_ARB_RR_EN for round-robin winner selection; otherwise fixed lowest-index priority.
module dma_channel_arbiter #(
  parameter int BURST_MAX = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ch_req,
  input  logic [3:0] ch_mask,
  input  logic       eng_busy,
  input  logic       eng_beat,
  input  logic       eng_err,
  input  logic       err_clr,
  output logic       eng_start,
  output logic       eng_stop,
  output logic       grant_vld,
  output logic [1:0] grant_ch,
  output logic [3:0] ch_ack,
  output logic       err_flag
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam logic [4:0] LAST_BEAT = 5'(BURST_MAX - 1);

  state_e     state_q, state_d;
  logic       grant_vld_q, grant_vld_d;
  logic [1:0] grant_ch_q, grant_ch_d;
  logic       eng_start_q, eng_start_d;
  logic       eng_stop_q, eng_stop_d;
  logic [3:0] ch_ack_q, ch_ack_d;
  logic       err_flag_q, err_flag_d;
  logic [4:0] beat_cnt_q, beat_cnt_d;
  logic [3:0] pend_s;
  logic [1:0] winner_s;
  logic       end_grant_s;

  assign pend_s      = ch_req & ch_mask;
  assign end_grant_s = eng_err | (eng_beat & ((beat_cnt_q == LAST_BEAT) |
                                              ~ch_req[grant_ch_q] | ~ch_mask[grant_ch_q]));

`ifdef DMA_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;

  // Descending scan so the nearest pending channel after the pointer is written last.
  always_comb begin
    logic [1:0] idx;
    idx      = 2'd0;
    winner_s = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      idx      = ptr_q + 2'(i);
      winner_s = pend_s[idx] ? idx : winner_s;
    end
    ptr_d = (state_q == RELEASE) ? grant_ch_q : ptr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 2'd0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    winner_s = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      winner_s = pend_s[i] ? 2'(i) : winner_s;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if ((pend_s != 4'd0) && !eng_busy) state_d = GRANT;
        else                               state_d = IDLE;
      end
      GRANT: state_d = XFER;
      XFER: begin
        if (end_grant_s) state_d = RELEASE;
        else             state_d = XFER;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered one state ahead so each pulse lines up with its state.
  always_comb begin
    grant_vld_d = grant_vld_q;
    grant_ch_d  = grant_ch_q;
    eng_start_d = 1'b0;
    eng_stop_d  = 1'b0;
    ch_ack_d    = 4'd0;
    beat_cnt_d  = beat_cnt_q;
    err_flag_d  = (eng_err | err_clr) ? eng_err : err_flag_q;
    case (state_q)
      IDLE: begin
        if (state_d == GRANT) begin
          grant_vld_d = 1'b1;
          grant_ch_d  = winner_s;
          eng_start_d = 1'b1;
        end else begin
          grant_vld_d = 1'b0;
        end
      end
      GRANT: beat_cnt_d = 5'd0;
      XFER: begin
        beat_cnt_d = eng_beat ? beat_cnt_q + 5'd1 : beat_cnt_q;
        if (state_d == RELEASE) begin
          eng_stop_d = 1'b1;
          ch_ack_d   = 4'b0001 << grant_ch_q;
        end else begin
          eng_stop_d = 1'b0;
        end
      end
      RELEASE: grant_vld_d = 1'b0;
      default: grant_vld_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_vld_q <= 1'b0;
      grant_ch_q  <= 2'd0;
      eng_start_q <= 1'b0;
      eng_stop_q  <= 1'b0;
      ch_ack_q    <= 4'd0;
      err_flag_q  <= 1'b0;
      beat_cnt_q  <= 5'd0;
    end else begin
      grant_vld_q <= grant_vld_d;
      grant_ch_q  <= grant_ch_d;
      eng_start_q <= eng_start_d;
      eng_stop_q  <= eng_stop_d;
      ch_ack_q    <= ch_ack_d;
      err_flag_q  <= err_flag_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign eng_start = eng_start_q;
  assign eng_stop  = eng_stop_q;
  assign grant_vld = grant_vld_q;
  assign grant_ch  = grant_ch_q;
  assign ch_ack    = ch_ack_q;
  assign err_flag  = err_flag_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench for dma_channel_arbiter: one instance at BURST_MAX=16, one at BURST_MAX=4 for contention.
module tb_dma_channel_arbiter;

`ifdef DMA_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] ch_req, ch_mask;
  logic       eng_busy, eng_beat, eng_err, err_clr;
  logic       a_start, a_stop, a_vld, a_err;
  logic [1:0] a_ch;
  logic [3:0] a_ack;
  logic       b_start, b_stop, b_vld, b_err;
  logic [1:0] b_ch;
  logic [3:0] b_ack;
  bit         sel;
  logic       o_start, o_stop;
  logic [1:0] o_ch;
  logic [3:0] o_ack;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  dma_channel_arbiter #(.BURST_MAX(16)) dut_a (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_mask(ch_mask), .eng_busy(eng_busy),
    .eng_beat(eng_beat), .eng_err(eng_err), .err_clr(err_clr), .eng_start(a_start),
    .eng_stop(a_stop), .grant_vld(a_vld), .grant_ch(a_ch), .ch_ack(a_ack), .err_flag(a_err));

  dma_channel_arbiter #(.BURST_MAX(4)) dut_b (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_mask(ch_mask), .eng_busy(eng_busy),
    .eng_beat(eng_beat), .eng_err(eng_err), .err_clr(err_clr), .eng_start(b_start),
    .eng_stop(b_stop), .grant_vld(b_vld), .grant_ch(b_ch), .ch_ack(b_ack), .err_flag(b_err));

  assign o_start = sel ? b_start : a_start;
  assign o_stop  = sel ? b_stop  : a_stop;
  assign o_ch    = sel ? b_ch    : a_ch;
  assign o_ack   = sel ? b_ack   : a_ack;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_start(output bit ok, output logic [1:0] ch, output int at);
    ok = 1'b0; ch = 2'd0; at = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_start === 1'b1) begin
        ok = 1'b1; ch = o_ch; at = cyc;
        break;
      end
    end
  endtask

  // Called at the negedge where eng_start is visible; beats every cycle until eng_stop.
  task automatic run_beats(input int drop_after, input logic [3:0] drop_req,
                           output bit ok, output int beats, output logic [3:0] ack, output int at);
    ok = 1'b0; beats = 0; ack = 4'd0; at = 0;
    @(negedge clk);
    eng_beat = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      beats++;
      if (o_stop === 1'b1) begin
        ok = 1'b1; ack = o_ack; at = cyc;
        break;
      end
      if (beats == drop_after) ch_req = drop_req;
    end
    eng_beat = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ch_req = 4'd0; ch_mask = 4'd0; eng_busy = 1'b0;
    eng_beat = 1'b0; eng_err = 1'b0; err_clr = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({a_start, a_stop, a_vld, a_ch, a_ack, a_err} !== 10'd0) begin
      n_err++; $display("FAIL reset_a: got %b want 0", {a_start, a_stop, a_vld, a_ch, a_ack, a_err});
    end
    n_vec++;
    if ({b_start, b_stop, b_vld, b_ch, b_ack, b_err} !== 10'd0) begin
      n_err++; $display("FAIL reset_b: got %b want 0", {b_start, b_stop, b_vld, b_ch, b_ack, b_err});
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int exp_beats[3] = '{16, 16, 8};
    int drop[3] = '{0, 0, 7};
    bit ok; logic [1:0] ch; logic [3:0] ack; int at, st, prev_stop, beats; bit seen;
    sel = 1'b0; ch_mask = 4'hF; ch_req = 4'b0100; prev_stop = 0;
    for (int k = 0; k < 3; k++) begin
      wait_start(ok, ch, at);
      n_vec++;
      if (!ok || ch !== 2'd2) begin
        n_err++; $display("FAIL single_grant[%0d]: got ok=%0d ch=%0d want ch=2", k, ok, ch);
      end
      if (k > 0) begin
        n_vec++;
        if (at - prev_stop !== 2) begin
          n_err++; $display("FAIL single_gap[%0d]: got %0d want 2", k, at - prev_stop);
        end
      end
      run_beats(drop[k], 4'b0000, ok, beats, ack, st);
      n_vec++;
      if (!ok || beats !== exp_beats[k] || ack !== 4'b0100) begin
        n_err++; $display("FAIL single_burst[%0d]: got beats=%0d ack=%b want beats=%0d ack=0100",
                          k, beats, ack, exp_beats[k]);
      end
      prev_stop = st;
    end
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (a_start === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL single_no_regrant: got start=%0d want 0", seen);
    end
  endtask

  task automatic test_mask_busy();
    bit ok, seen; logic [1:0] ch; logic [3:0] ack; int at, beats;
    sel = 1'b0; ch_req = 4'hF; ch_mask = 4'b0000; seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (a_vld === 1'b1 || a_start === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL mask_zero: got grant=%0d want 0", seen);
    end
    ch_mask = 4'b1000; eng_busy = 1'b1; seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (a_vld === 1'b1 || a_start === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL busy_hold: got grant=%0d want 0", seen);
    end
    eng_busy = 1'b0;
    wait_start(ok, ch, at);
    n_vec++;
    if (!ok || ch !== 2'd3) begin
      n_err++; $display("FAIL busy_release_grant: got ok=%0d ch=%0d want ch=3", ok, ch);
    end
    run_beats(1, 4'b0000, ok, beats, ack, at);
    n_vec++;
    if (!ok || beats !== 2 || ack !== 4'b1000) begin
      n_err++; $display("FAIL busy_burst: got beats=%0d ack=%b want beats=2 ack=1000", beats, ack);
    end
    ch_req = 4'd0; ch_mask = 4'hF;
  endtask

  task automatic test_early_drop();
    bit ok; logic [1:0] ch, e; logic [3:0] ack; int at, beats;
    sel = 1'b0; ch_mask = 4'hF; ch_req = 4'b0010;
    wait_start(ok, ch, at);
    n_vec++;
    if (!ok || ch !== 2'd1) begin
      n_err++; $display("FAIL drop_grant: got ok=%0d ch=%0d want ch=1", ok, ch);
    end
    run_beats(2, 4'b1101, ok, beats, ack, at);
    n_vec++;
    if (!ok || beats !== 3 || ack !== 4'b0010) begin
      n_err++; $display("FAIL drop_release: got beats=%0d ack=%b want beats=3 ack=0010", beats, ack);
    end
    n_vec++;
    if (a_ch !== 2'd1) begin
      n_err++; $display("FAIL drop_ch_stable: got %0d want 1", a_ch);
    end
    e = RR ? 2'd2 : 2'd0;
    wait_start(ok, ch, at);
    n_vec++;
    if (!ok || ch !== e) begin
      n_err++; $display("FAIL drop_next_grant: got ok=%0d ch=%0d want ch=%0d", ok, ch, e);
    end
    run_beats(1, 4'b0000, ok, beats, ack, at);
    n_vec++;
    if (!ok || beats !== 2 || ack !== (4'b0001 << e)) begin
      n_err++; $display("FAIL drop_next_burst: got beats=%0d ack=%b want beats=2", beats, ack);
    end
  endtask

  task automatic test_error();
    bit ok; logic [1:0] ch; int at;
    sel = 1'b0; ch_mask = 4'hF; ch_req = 4'b0001;
    wait_start(ok, ch, at);
    n_vec++;
    if (!ok || ch !== 2'd0) begin
      n_err++; $display("FAIL err_grant: got ok=%0d ch=%0d want ch=0", ok, ch);
    end
    @(negedge clk);
    eng_beat = 1'b1;
    repeat (4) @(negedge clk);
    eng_err = 1'b1;
    @(negedge clk);
    eng_err = 1'b0; eng_beat = 1'b0; ch_req = 4'd0;
    n_vec++;
    if (a_stop !== 1'b1 || a_err !== 1'b1 || a_ack !== 4'b0001) begin
      n_err++; $display("FAIL err_release: got stop=%0d err=%0d ack=%b want 1 1 0001", a_stop, a_err, a_ack);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_vec++;
    if (a_err !== 1'b0) begin
      n_err++; $display("FAIL err_clear: got %0d want 0", a_err);
    end
    eng_err = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    eng_err = 1'b0; err_clr = 1'b0;
    n_vec++;
    if (a_err !== 1'b1) begin
      n_err++; $display("FAIL err_set_wins: got %0d want 1", a_err);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_vec++;
    if (a_err !== 1'b0) begin
      n_err++; $display("FAIL err_clear2: got %0d want 0", a_err);
    end
  endtask

  task automatic test_reset_xfer();
    bit ok; logic [1:0] ch, e; logic [3:0] ack; int at, beats;
    sel = 1'b0; ch_mask = 4'hF; ch_req = 4'b0100;
    wait_start(ok, ch, at);
    n_vec++;
    if (!ok || ch !== 2'd2) begin
      n_err++; $display("FAIL rstx_grant: got ok=%0d ch=%0d want ch=2", ok, ch);
    end
    @(negedge clk);
    eng_beat = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({a_start, a_stop, a_vld, a_ch, a_ack} !== 9'd0) begin
      n_err++; $display("FAIL rstx_async: got %b want 0", {a_start, a_stop, a_vld, a_ch, a_ack});
    end
    eng_beat = 1'b0; ch_req = 4'b0011;
    repeat (2) @(negedge clk);
    n_vec++;
    if (a_ack !== 4'd0 || a_stop !== 1'b0 || a_vld !== 1'b0) begin
      n_err++; $display("FAIL rstx_hold: got ack=%b stop=%0d vld=%0d want 0", a_ack, a_stop, a_vld);
    end
    reset = 1'b0;
    e = RR ? 2'd1 : 2'd0;
    wait_start(ok, ch, at);
    n_vec++;
    if (!ok || ch !== e) begin
      n_err++; $display("FAIL rstx_regrant: got ok=%0d ch=%0d want ch=%0d", ok, ch, e);
    end
    run_beats(1, 4'b0000, ok, beats, ack, at);
    n_vec++;
    if (!ok || beats !== 2 || ack !== (4'b0001 << e)) begin
      n_err++; $display("FAIL rstx_burst: got beats=%0d ack=%b want beats=2", beats, ack);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_rr[4] = '{2'd0, 2'd1, 2'd3, 2'd0};
    bit ok; logic [1:0] ch, e; logic [3:0] ack; int at, beats;
    sel = 1'b1; reset = 1'b1; ch_req = 4'd0; ch_mask = 4'hF;
    repeat (2) @(negedge clk);
    reset = 1'b0; ch_req = 4'b1000;
    wait_start(ok, ch, at);
    n_vec++;
    if (!ok || ch !== 2'd3) begin
      n_err++; $display("FAIL cont_seed: got ok=%0d ch=%0d want ch=3", ok, ch);
    end
    run_beats(0, 4'b0000, ok, beats, ack, at);
    n_vec++;
    if (!ok || beats !== 4 || ack !== 4'b1000) begin
      n_err++; $display("FAIL cont_seed_burst: got beats=%0d ack=%b want beats=4 ack=1000", beats, ack);
    end
    ch_req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      e = RR ? exp_rr[k] : 2'd0;
      wait_start(ok, ch, at);
      n_vec++;
      if (!ok || ch !== e) begin
        n_err++; $display("FAIL cont_order[%0d]: got ok=%0d ch=%0d want ch=%0d", k, ok, ch, e);
      end
      run_beats(0, 4'b0000, ok, beats, ack, at);
      n_vec++;
      if (!ok || beats !== 4 || ack !== (4'b0001 << e)) begin
        n_err++; $display("FAIL cont_burst[%0d]: got beats=%0d ack=%b want beats=4", k, beats, ack);
      end
    end
    ch_req = 4'd0;
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_mask_busy();
    test_early_drop();
    test_error();
    test_reset_xfer();
    test_contention();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
